// File: rtl/hex_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl_if
//
// Purpose: bundles the datapath-facing controls and the segment outputs of
// the multi-digit hex display controller so a producer (register block, debug
// logic, testbench) can hand one object to the controller.
//
// Signals (DIGITS = number of hex digits, 1..8):
//   load       capture `value` into the controller's shadow register
//   value      packed nibbles, digit i = value[4i+3:4i], digit 0 least significant
//   blank_lz   enable leading-zero blanking
//   blink_en   bit i = 1 makes digit i blink
//   lamp_test  force every segment of every digit lit
//   segs       registered segment outputs, digit i = segs[7i+6:7i], bit0 = a .. bit6 = g
//
// Modports:
//   master  drives the controls, observes segs
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface hex_display_ctrl_if #(
  parameter int DIGITS = 4
) ();

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blank_lz;
  logic [DIGITS-1:0]     blink_en;
  logic                  lamp_test;
  logic [7*DIGITS-1:0]   segs;

  modport master (
    output load,
    output value,
    output blank_lz,
    output blink_en,
    output lamp_test,
    input  segs
  );

  modport slave (
    input  load,
    input  value,
    input  blank_lz,
    input  blink_en,
    input  lamp_test,
    output segs
  );

endinterface

// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//
// Purpose: multi-digit hexadecimal seven-segment display controller. A packed
// hex value is captured into a shadow register on a load strobe and decoded
// into DIGITS registered seven-segment patterns, with leading-zero blanking,
// per-digit blinking driven by an internal prescaler, and a lamp test.
//
// Parameters:
//   DIGITS      number of hex digits driven, 1..8
//   BLINK_DIV   clock cycles per blink half-period, >= 1
//   ACTIVE_LOW  1 = a segment is lit by driving 0, 0 = lit by driving 1
//
// Ports:
//   clock   system clock, all state changes on the rising edge
//   reset   synchronous, active-high reset
//   bus     hex_display_ctrl_if.slave (load, value, blank_lz, blink_en,
//           lamp_test in; segs out)
//
// Latency: value sampled on a load edge appears on segs after the following
// edge; blank_lz, blink_en and lamp_test reach segs on the edge that samples
// them.
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clock,
  input  logic              reset,
  hex_display_ctrl_if.slave bus
);

  // Prescaler width; a divider of 1 still needs a one-bit counter that
  // simply sits at zero and wraps on every edge.
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BCNT_MAX = CW'(BLINK_DIV - 1);

  // All segments dark, in output polarity.
  localparam logic [7*DIGITS-1:0] SEGS_BLANK =
    (ACTIVE_LOW != 0) ? {(7*DIGITS){1'b1}} : {(7*DIGITS){1'b0}};

  localparam logic [6:0] PAT_ALL_ON = 7'h7F;
  localparam logic [6:0] PAT_DARK   = 7'h00;

  // Blink generator: SHOW displays every digit, HIDE blanks the digits
  // whose blink_en bit is set.
  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } phase_t;

  logic [4*DIGITS-1:0] shadow_q;
  logic [CW-1:0]       bcnt_q;
  phase_t              phase_q;
  logic [7*DIGITS-1:0] segs_q;
  logic [7*DIGITS-1:0] segs_d;

  logic [3:0]          nib;
  logic [6:0]          pat;
  logic                zeroFromTop;

  // Active-high hex to seven-segment decode (bit0 = a ... bit6 = g).
  function automatic logic [6:0] decodeNibble(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Next segment pattern for every digit. Digits are walked from the most
  // significant downwards so zeroFromTop tells whether this digit and all
  // digits above it are zero, which is exactly the leading-zero condition.
  // Digit 0 is exempt so an all-zero value still shows a single "0".
  // Priority per digit: lamp test, blink hide, leading-zero blank, decode.
  always_comb begin
    segs_d      = '0;
    zeroFromTop = 1'b1;
    nib         = 4'h0;
    pat         = PAT_DARK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib         = shadow_q[4*i +: 4];
      zeroFromTop = zeroFromTop & (nib == 4'h0);
      if (bus.lamp_test) begin
        pat = PAT_ALL_ON;
      end else if (bus.blink_en[i] && (phase_q == HIDE)) begin
        pat = PAT_DARK;
      end else if (bus.blank_lz && zeroFromTop && (i != 0)) begin
        pat = PAT_DARK;
      end else begin
        pat = decodeNibble(nib);
      end
      segs_d[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
    end
  end

  // All state lives here: shadow capture, blink prescaler, the SHOW/HIDE
  // blink machine and the output register. A load restarts the blink cycle
  // in SHOW so freshly loaded digits are visible at once, and it wins over a
  // wrap on the same edge. Reset wins over everything, including load.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= '0;
      bcnt_q   <= '0;
      phase_q  <= SHOW;
      segs_q   <= SEGS_BLANK;
    end else begin
      segs_q <= segs_d;
      if (bus.load) begin
        shadow_q <= bus.value;
        bcnt_q   <= '0;
        phase_q  <= SHOW;
      end else if (bcnt_q == BCNT_MAX) begin
        bcnt_q <= '0;
        case (phase_q)
          SHOW:    phase_q <= HIDE;
          default: phase_q <= SHOW;
        endcase
      end else begin
        bcnt_q <= bcnt_q + CW'(1);
      end
    end
  end

  assign bus.segs = segs_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_display_ctrl
//
// Purpose: self-checking bench for hex_display_ctrl. Two instances run side
// by side: a 4-digit active-low one with a short blink divider, and a
// 1-digit active-high one with a divider of 1. A behavioural model tracks
// the shadow value and the number of edges since the last blink restart and
// predicts segs for both on every edge.
// ---------------------------------------------------------------------------
module tb_hex_display_ctrl;

  localparam int D0_DIGITS = 4;
  localparam int D0_DIV    = 4;
  localparam int D1_DIGITS = 1;
  localparam int D1_DIV    = 1;

  logic clock = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  // Model state: shadow value and edges since the blink cycle restarted.
  logic [15:0] mShadow0;
  int          mCount0;
  logic [3:0]  mShadow1;
  int          mCount1;

  logic [6:0] decTab [16];

  // Table vectors for the 4-digit instance, blinking off.
  typedef struct {
    logic            load;
    logic [15:0]     value;
    logic            blz;
    logic            lamp;
    logic [3:0][6:0] expSegs;
  } vec_t;

  vec_t vecs [9];

  hex_display_ctrl_if #(.DIGITS(D0_DIGITS)) bus0 ();
  hex_display_ctrl_if #(.DIGITS(D1_DIGITS)) bus1 ();

  hex_display_ctrl #(
    .DIGITS(D0_DIGITS), .BLINK_DIV(D0_DIV), .ACTIVE_LOW(1)
  ) dut0 (
    .clock(clock),
    .reset(reset),
    .bus  (bus0)
  );

  hex_display_ctrl #(
    .DIGITS(D1_DIGITS), .BLINK_DIV(D1_DIV), .ACTIVE_LOW(0)
  ) dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (bus1)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Segment prediction straight from the display rules: a digit is a leading
  // zero when the value shifted down to that digit is zero.
  function automatic logic [55:0] modelSegs(input int digits, input bit activeLow,
                                            input logic [31:0] shadow, input logic blz,
                                            input logic [7:0] blinkEn, input logic lamp,
                                            input bit hide);
    logic [55:0] r;
    logic [6:0]  p;
    logic [31:0] masked;
    r = '0;
    masked = (digits >= 8) ? shadow : (shadow & ((32'h1 << (4*digits)) - 1));
    for (int i = 0; i < digits; i++) begin
      if (lamp) p = 7'h7F;
      else if (blinkEn[i] && hide) p = 7'h00;
      else if (blz && i != 0 && (masked >> (4*i)) == 0) p = 7'h00;
      else p = decTab[(masked >> (4*i)) & 32'hF];
      if (activeLow) p = ~p;
      r[7*i +: 7] = p;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [55:0] act, input logic [55:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock edge: predict from pre-edge state and inputs, advance the
  // model, wait for the edge, then compare both instances.
  task automatic applyStimulus();
    logic [55:0] e0, e1;
    if (reset) begin
      e0 = 56'(28'hFFFFFFF);
      e1 = '0;
    end else begin
      e0 = modelSegs(D0_DIGITS, 1'b1, 32'(mShadow0), bus0.blank_lz, 8'(bus0.blink_en),
                     bus0.lamp_test, ((mCount0 / D0_DIV) % 2) == 1);
      e1 = modelSegs(D1_DIGITS, 1'b0, 32'(mShadow1), bus1.blank_lz, 8'(bus1.blink_en),
                     bus1.lamp_test, ((mCount1 / D1_DIV) % 2) == 1);
    end
    if (reset) begin
      mShadow0 = '0; mCount0 = 0;
      mShadow1 = '0; mCount1 = 0;
    end else begin
      if (bus0.load) begin mShadow0 = bus0.value; mCount0 = 0; end
      else mCount0 = (mCount0 + 1) % (2 * D0_DIV);
      if (bus1.load) begin mShadow1 = bus1.value; mCount1 = 0; end
      else mCount1 = (mCount1 + 1) % (2 * D1_DIV);
    end
    @(posedge clock);
    #1;
    checkOutput("model0", 56'(bus0.segs), e0);
    checkOutput("model1", 56'(bus1.segs), e1);
  endtask

  task automatic setBus0(input logic ld, input logic [15:0] v, input logic blz,
                         input logic [3:0] be, input logic lt);
    bus0.load = ld; bus0.value = v; bus0.blank_lz = blz;
    bus0.blink_en = be; bus0.lamp_test = lt;
  endtask

  initial begin
    decTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[1] = '{1'b0, 16'h1234, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[2] = '{1'b1, 16'h0000, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[3] = '{1'b1, 16'h00A0, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{1'b0, 16'h00A0, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h08, 7'h40}};
    vecs[5] = '{1'b0, 16'h00A0, 1'b1, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[6] = '{1'b0, 16'h00A0, 1'b0, 1'b0, {7'h40, 7'h40, 7'h08, 7'h40}};
    vecs[7] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, {7'h40, 7'h40, 7'h08, 7'h40}};
    vecs[8] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};

    mShadow0 = '0; mCount0 = 0; mShadow1 = '0; mCount1 = 0;
    reset = 1'b1;
    setBus0(1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    bus1.load = 1'b0; bus1.value = 4'h0; bus1.blank_lz = 1'b0;
    bus1.blink_en = 1'b0; bus1.lamp_test = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_blank", 56'(bus0.segs), 56'(28'hFFFFFFF));
    reset = 1'b0;

    // Table-driven decode, leading-zero and lamp-test vectors.
    for (int i = 0; i < 9; i++) begin
      setBus0(vecs[i].load, vecs[i].value, vecs[i].blz, 4'h0, vecs[i].lamp);
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), 56'(bus0.segs), 56'(vecs[i].expSegs));
    end

    // Blinking digit 0: visible for 4 edges, hidden for 4, after a load.
    setBus0(1'b1, 16'hFFFF, 1'b0, 4'b0001, 1'b0);
    applyStimulus();
    bus0.load = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      applyStimulus();
      checkOutput($sformatf("blink_d0_e%0d", e), 56'(bus0.segs[6:0]),
                  56'((((e - 1) / 4) % 2) == 1 ? 7'h7F : 7'h0E));
      checkOutput($sformatf("blink_hi_e%0d", e), 56'(bus0.segs[27:7]), 56'({3{7'h0E}}));
    end
    // Load while hidden: that edge still hides, the next edge shows.
    bus0.load = 1'b1;
    applyStimulus();
    checkOutput("load_in_hide", 56'(bus0.segs[6:0]), 56'(7'h7F));
    bus0.load = 1'b0;
    applyStimulus();
    checkOutput("load_restart_show", 56'(bus0.segs[6:0]), 56'(7'h0E));

    // Lamp test during HIDE with all digits blinking.
    bus0.blink_en = 4'hF;
    for (int k = 0; k < 3; k++) applyStimulus();
    applyStimulus();
    checkOutput("all_hidden", 56'(bus0.segs), 56'(28'hFFFFFFF));
    bus0.lamp_test = 1'b1;
    applyStimulus();
    checkOutput("lamp_in_hide", 56'(bus0.segs), 56'(28'h0));
    bus0.lamp_test = 1'b0;
    bus0.blink_en  = 4'h0;
    applyStimulus();
    checkOutput("lamp_release", 56'(bus0.segs), 56'({4{7'h0E}}));

    // Reset together with load of BEEF and lamp test: nothing captured.
    reset = 1'b1;
    setBus0(1'b1, 16'hBEEF, 1'b0, 4'h0, 1'b1);
    applyStimulus();
    checkOutput("reset_over_load", 56'(bus0.segs), 56'(28'hFFFFFFF));
    reset = 1'b0;
    setBus0(1'b0, 16'h0, 1'b0, 4'h0, 1'b0);
    applyStimulus();
    checkOutput("no_capture", 56'(bus0.segs), 56'({4{7'h40}}));

    // Active-high single digit: full nibble sweep.
    for (int n = 0; n < 16; n++) begin
      bus1.value = 4'(n);
      bus1.load  = 1'b1;
      applyStimulus();
      bus1.load  = 1'b0;
      applyStimulus();
      checkOutput($sformatf("sweep_%0h", n), 56'(bus1.segs), 56'(decTab[n]));
    end

    // Divider of 1: blinking digit alternates every edge.
    bus1.value = 4'hD; bus1.load = 1'b1;
    applyStimulus();
    bus1.load = 1'b0; bus1.blink_en = 1'b1;
    for (int e = 0; e < 4; e++) begin
      applyStimulus();
      checkOutput($sformatf("div1_e%0d", e), 56'(bus1.segs),
                  56'((e % 2) == 1 ? 7'h00 : 7'h5E));
    end

    // Randomised traffic checked against the model inside applyStimulus.
    for (int r = 0; r < 400; r++) begin
      reset = ($urandom_range(63) == 0);
      setBus0(($urandom_range(7) == 0), 16'($urandom), 1'($urandom),
              4'($urandom), ($urandom_range(9) == 0));
      if ($urandom_range(1) == 0) bus0.value = 16'($urandom_range(255));
      bus1.load      = ($urandom_range(5) == 0);
      bus1.value     = 4'($urandom);
      bus1.blank_lz  = 1'($urandom);
      bus1.blink_en  = 1'($urandom);
      bus1.lamp_test = ($urandom_range(9) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit hexadecimal seven-segment display controller that generalises the single-digit 4-bit-to-7-segment decoder. It captures a packed hex value on a load strobe and drives DIGITS registered seven-segment outputs. It adds leading-zero blanking, per-digit blinking from an internal prescaler, and a lamp test. It sits between datapath or debug registers and the board HEX displays.

## Interface
- DIGITS, 4: number of hex digits driven; legal range 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period; minimum 1.
- ACTIVE_LOW, 1: 1 = segment lit by driving 0 (board HEX displays); 0 = lit by driving 1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture `value` into the shadow register on this edge.
- value  in  4*DIGITS  packed nibbles; digit i = value[4i+3:4i], digit 0 least significant.
- blank_lz  in  1  enable leading-zero blanking.
- blink_en  in  DIGITS  bit i = 1 makes digit i blink.
- lamp_test  in  1  force all segments of all digits lit.
- segs  out  7*DIGITS  digit i = segs[7i+6:7i]; bit0 = a (top), 1 = b, 2 = c, 3 = d, 4 = e, 5 = f, 6 = g (middle); registered.

## Operation
- Shadow register `shadow` (4*DIGITS bits) is loaded from `value` on a clock edge when load = 1 and otherwise holds.
- Decode, active-high, before polarity:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Leading-zero blanking, when blank_lz = 1:
  - Digit i is blanked (00) iff it and every higher digit are 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Blink prescaler:
  - Counter `bcnt` counts 0..BLINK_DIV-1 continuously, independent of blink_en.
  - On the wrap edge (bcnt = BLINK_DIV-1), bcnt returns to 0 and `phase` toggles.
  - phase = 0 means shown; phase = 1 means blinking digits are blanked.
- A load edge restarts blinking: bcnt <= 0 and phase <= 0 on the same edge as the capture, so a new value is visible immediately. Load overrides a simultaneous wrap.
- Per-digit priority, highest first:
  - lamp_test → 7F
  - blink_en[i] & phase → 00
  - leading-zero blank → 00
  - decode of shadow nibble
- Polarity: when ACTIVE_LOW = 1, the active-high pattern is inverted before registering.
- Blanked means all segments dark: 7F when ACTIVE_LOW = 1, 00 when ACTIVE_LOW = 0.
- The internal state is exactly shadow, bcnt, phase and the segs register. The blink generator is a 2-state machine, SHOW ↔ HIDE, advancing on wrap and forced to SHOW by load or reset.

## Timing
- Reset, when reset = 1 on an edge:
  - shadow = 0, bcnt = 0, phase = 0 (SHOW).
  - segs = all digits blanked (all ones when ACTIVE_LOW = 1).
  - Reset overrides load and lamp_test on the same edge.
- After reset deasserts, segs shows "0" in digit 0 and higher digits follow blank_lz, starting from the first non-reset edge.
- Latency: `value` sampled at load edge k → segs reflects it after edge k+1 (two-edge latency).
- blank_lz, blink_en and lamp_test each affect segs one edge after being sampled.
- Blink period is 2*BLINK_DIV cycles. With BLINK_DIV = 1, phase toggles every edge.
- Reset mid-blink or mid-load discards everything: no partial capture, and the phase restarts in SHOW.
- load held high recaptures every edge and holds the blinker in SHOW.

## Test plan
- Reset, then DIGITS=4, ACTIVE_LOW=1, load value=16'h1234, blank_lz=0 → two edges later segs = {4F^7F, 5B^7F, 06^7F... } i.e. digit3..0 = 7F-inverted patterns of 1,2,3,4: digit3=79, digit2=24, digit1=30, digit0=19.
- Load 16'h0000 then 16'h00A0 with blank_lz=1 → first shows digits 3..1 = 7F and digit0 = 40 ("0"); second shows digits 3,2 = 7F, digit1 = 08 ("A"), digit0 = 40.
- BLINK_DIV=4, blink_en=4'b0001, value=16'hFFFF → digit0 alternates 0E / 7F every 4 cycles (period 8) while digits 3..1 stay 0E; a load in the HIDE phase shows digit0 on the following edge.
- lamp_test=1 with blink_en=4'b1111 during the HIDE phase → all digits = 00 (all lit) one edge later; on release, normal decode resumes.
- Assert reset mid-sequence together with load of 16'hBEEF → segs = all 7F after that edge, shadow = 0, and the value is not captured.
- ACTIVE_LOW=0, DIGITS=1, sweep all 16 nibbles → segs equals the decode list exactly, e.g. d → 5E, F → 71.
